// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for register_file with busy scoreboard and read-hazard flags.
// Optional forwarding from the WB stage is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_gnt,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_stall,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic              haz_a,
  output logic              haz_b,
  output logic [NREGS-1:0]  busy_vec,
  output logic [DATA_W-1:0] rf_C,
  output logic [ADDR_W-1:0] rf_rc,
  output logic              rf_le
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic              fwd_a_valid,
  output logic              fwd_b_valid,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data
`endif
);

  typedef enum logic {PRI_ALU, PRI_MEM} pri_t;

  pri_t              pri_q, pri_d;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              wb_valid;
  logic              wb_hit_a, wb_hit_b;

  // Priority pointer: names the requester that wins the next tie.
  always_ff @(posedge clk) begin
    if (clr) pri_q <= PRI_ALU;
    else     pri_q <= pri_d;
  end

  always_comb begin
    pri_d = pri_q;
    if (alu_gnt)      pri_d = PRI_MEM;
    else if (mem_gnt) pri_d = PRI_ALU;
  end

  always_comb begin
    alu_gnt  = alu_req & (~mem_req | (pri_q == PRI_ALU));
    mem_gnt  = mem_req & (~alu_req | (pri_q == PRI_MEM));
    gnt_any  = alu_gnt | mem_gnt;
    gnt_rd   = alu_gnt ? alu_rd   : mem_rd;
    gnt_data = alu_gnt ? alu_data : mem_data;
  end

  // Writeback register: rf_C/rf_rc hold their last value when no grant arrives.
  always_ff @(posedge clk) begin
    if (clr) begin
      wb_valid <= 1'b0;
      rf_C     <= '0;
      rf_rc    <= '0;
    end else begin
      wb_valid <= gnt_any;
      if (gnt_any) begin
        rf_C  <= gnt_data;
        rf_rc <= gnt_rd;
      end
    end
  end

  assign rf_le = ~wb_valid;

  // A grant retiring iss_rd this cycle frees it, so the issue may proceed.
  assign iss_stall = iss_valid & busy_q[iss_rd] & ~(gnt_any & (gnt_rd == iss_rd));

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any)                busy_d[gnt_rd] = 1'b0;
    if (iss_valid & ~iss_stall) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign wb_hit_a = wb_valid & (rf_rc == rs_a);
  assign wb_hit_b = wb_valid & (rf_rc == rs_b);

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    fwd_a_valid = wb_hit_a & ~busy_q[rs_a];
    fwd_b_valid = wb_hit_b & ~busy_q[rs_b];
    fwd_a_data  = fwd_a_valid ? rf_C : '0;
    fwd_b_data  = fwd_b_valid ? rf_C : '0;
    haz_a       = busy_q[rs_a] | (wb_hit_a & ~fwd_a_valid);
    haz_b       = busy_q[rs_b] | (wb_hit_b & ~fwd_b_valid);
  end
`else
  always_comb begin
    haz_a = busy_q[rs_a] | wb_hit_a;
    haz_b = busy_q[rs_b] | wb_hit_b;
  end
`endif

endmodule
